ds_adc_multichan: RTL and testbench
===================================

Name: ds_adc_multichan

Overview:
- Parametrised successor of the two-channel delta-sigma comparator ADC top.
- NCH comparator channels, each with:
  - a sampling flip-flop and an inverted PDM feedback output;
  - an inline sinc^STAGES CIC decimator.
- All channel results are snapshotted on an external trigger and shipped as a single framed serial stream on one data pin.
- Sits between the off-chip RC/comparator pins and the host readout.

Parameters:
- NCH, 2: number of comparator channels (>=1; >=2 when DIFF_WORD_EN is defined).
- STAGES, 4: CIC integrator/comb stage count.
- DECIM, 8: decimation ratio (power of two, >=2).
- WIDTH, 16: CIC datapath and output word width. Requires STAGES*log2(DECIM)+1 <= WIDTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- cmp_in  in  NCH  comparator levels, already synchronous to clk.
- pdm_fb  out  NCH  feedback drive to RC network, = ~sampling FF.
- trigger  in  1  readout request, synchronous to clk, rising-edge sensitive.
- dec_strobe  out  1  one-cycle pulse each time the CIC outputs update.
- ser_data  out  1  serial frame bit, MSB first.
- ser_valid  out  1  high for every frame bit.
- ser_frame  out  1  high on the first bit of a frame only.
- busy  out  1  frame in progress (equals ser_valid).
- overrun  out  1  one-cycle pulse when a trigger edge is dropped.

Behaviour:
- Reset (rst high at a clk edge) sets all state on that edge:
  - sampling FFs = 1, so pdm_fb = 0 (capacitor charging);
  - integrators, combs, decimation counter, cic_out and snapshot = 0;
  - FSM = IDLE; ser_data, ser_valid, ser_frame, busy, overrun, dec_strobe = 0;
  - trigger history register = 1, so a trigger held high across reset release does not start a frame.
- Reset mid-frame aborts the frame. Outputs go to reset values at that edge. No partial continuation after release.
- Sampling: ff[i] <= cmp_in[i] each cycle; pdm_fb[i] = ~ff[i] combinational.
- CIC, per channel:
  - Integrators accumulate ff[i] zero-extended to WIDTH every cycle, wrapping modulo 2^WIDTH.
  - Decimation counter runs 0..DECIM-1.
  - On the edge where the counter equals DECIM-1: the comb chain processes the last integrator value, cic_out[i] is registered, and dec_strobe is high for the following cycle.
  - Comb arithmetic wraps modulo 2^WIDTH.
  - Constant input 1 gives cic_out = DECIM^STAGES (0x1000 at defaults) from the (STAGES+2)th strobe onward. Constant 0 gives 0.
- Trigger detect: edge = trigger & ~trig_q; trig_q <= trigger every cycle.
- FSM states IDLE and SHIFT:
  - IDLE, edge at clock edge E: load snapshot of all cic_out (pre-update value if a CIC update coincides with E), load bit counter, go to SHIFT.
  - SHIFT: frame bit k is presented after edge E+k for k = 0..L-1, where L = NCH*WIDTH (plus WIDTH with DIFF_WORD_EN).
  - Word order is channel 0 first, each word MSB first.
  - ser_frame = 1 only for k = 0.
  - After edge E+L: return to IDLE; ser_valid, busy and ser_data = 0.
  - ser_data = 0 whenever ser_valid = 0.
- Trigger edge while in SHIFT, including the last bit cycle: ignored, the frame is unaffected, and overrun pulses high the cycle after that edge.
- Trigger held high: exactly one frame; a new low->high transition is required.
- Back-to-back: an edge on the cycle right after the frame returns to IDLE is accepted.

Optional Feature:
- Macro DIFF_WORD_EN.
- Defined: one extra word is appended after the last channel word: (cic_out[0] - cic_out[1]) modulo 2^WIDTH, two's complement, snapshotted at the same edge E. L = (NCH+1)*WIDTH.
- Undefined: no difference word, no subtractor logic, L = NCH*WIDTH.

Test Plan:
- Reset, cmp_in held 00: pdm_fb = 00 while rst high. After release, pdm_fb = 11 one cycle later. No dec_strobe before DECIM cycles.
- Defaults, cmp_in[0] = 1 and cmp_in[1] = 0 constant, wait 10 strobes, pulse trigger:
  - 32 valid bits: 0x1000 then 0x0000; ser_frame high on bit 0 only; busy low after 32 cycles.
  - With DIFF_WORD_EN: 48 bits ending 0x1000.
- DIFF_WORD_EN, cmp_in[0] = 0 and cmp_in[1] = 1 constant: difference word = 0xF000.
- cmp_in[0] toggling 1,0,1,0 every cycle: channel 0 word = 0x0800 after settling.
- Second trigger edge at frame bit 20: frame continues unchanged for all 32 bits; overrun = 1 for exactly one cycle; no second frame follows.
- Trigger held high through reset release: no frame. Start a frame, then assert rst at bit 10: ser_valid, busy and ser_data = 0 at the next edge, and no bits after release.

Source files
------------

// File: rtl/ds_adc_multichan.sv
// Multichannel delta-sigma comparator ADC: per-channel sampling FF, sinc^STAGES CIC, framed serial readout.
// Define DIFF_WORD_EN to append the channel 0 minus channel 1 difference word to every frame.
module ds_adc_multichan #(
    parameter int NCH    = 2,
    parameter int STAGES = 4,
    parameter int DECIM  = 8,
    parameter int WIDTH  = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] cmp_in,
    output logic [NCH-1:0] pdm_fb,
    input  logic           trigger,
    output logic           dec_strobe,
    output logic           ser_data,
    output logic           ser_valid,
    output logic           ser_frame,
    output logic           busy,
    output logic           overrun
);

`ifdef DIFF_WORD_EN
    localparam int NWORDS = NCH + 1;
`else
    localparam int NWORDS = NCH;
`endif
    localparam int L  = NWORDS * WIDTH;
    localparam int CW = $clog2(DECIM);
    localparam int BW = $clog2(L);
    localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(L - 1);

    // Comb chain evaluated in one pass: low STAGES words are the new delay taps, top word is the result.
    function automatic logic [(STAGES+1)*WIDTH-1:0] comb_chain(
        input logic [WIDTH-1:0]        x,
        input logic [STAGES*WIDTH-1:0] dly
    );
        logic [WIDTH-1:0]              v;
        logic [(STAGES+1)*WIDTH-1:0]   res;
        v   = x;
        res = '0;
        for (int s = 0; s < STAGES; s++) begin
            res[s*WIDTH +: WIDTH] = v;
            v = v - dly[s*WIDTH +: WIDTH];
        end
        res[STAGES*WIDTH +: WIDTH] = v;
        return res;
    endfunction

`ifdef DIFF_WORD_EN
    function automatic logic signed [WIDTH-1:0] wrap_diff(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        return a - b;
    endfunction
`endif

    // p0: comparator sampling
    logic [NCH-1:0] samp_p0;

    always_ff @(posedge clk) begin
        if (rst) samp_p0 <= '1;
        else     samp_p0 <= cmp_in;
    end

    assign pdm_fb = ~samp_p0;

    // p1: integrators, p2: decimated comb output
    logic [WIDTH-1:0]              integ_p1   [NCH][STAGES];
    logic [STAGES*WIDTH-1:0]       comb_dly   [NCH];
    logic [(STAGES+1)*WIDTH-1:0]   comb_res   [NCH];
    logic [WIDTH-1:0]              cic_out_p2 [NCH];
    logic [CW-1:0]                 dec_cnt;
    logic                          dec_last;
    logic                          vld_p2;

    assign dec_last = (dec_cnt == CNT_LAST);

    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            comb_res[ch] = comb_chain(integ_p1[ch][STAGES-1], comb_dly[ch]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_cnt <= '0;
            vld_p2  <= 1'b0;
            for (int ch = 0; ch < NCH; ch++) begin
                for (int s = 0; s < STAGES; s++) integ_p1[ch][s] <= '0;
                comb_dly[ch]   <= '0;
                cic_out_p2[ch] <= '0;
            end
        end else begin
            dec_cnt <= dec_last ? '0 : dec_cnt + CW'(1);
            vld_p2  <= dec_last;
            for (int ch = 0; ch < NCH; ch++) begin
                integ_p1[ch][0] <= integ_p1[ch][0] + WIDTH'(samp_p0[ch]);
                for (int s = 1; s < STAGES; s++) begin
                    integ_p1[ch][s] <= integ_p1[ch][s] + integ_p1[ch][s-1];
                end
                if (dec_last) begin
                    comb_dly[ch]   <= comb_res[ch][STAGES*WIDTH-1:0];
                    cic_out_p2[ch] <= comb_res[ch][STAGES*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign dec_strobe = vld_p2;

    // Frame image: channel 0 in the top word so the shift register emits it first.
    logic [L-1:0] snap_d;

    always_comb begin
        snap_d = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            snap_d[L-1-ch*WIDTH -: WIDTH] = cic_out_p2[ch];
        end
`ifdef DIFF_WORD_EN
        snap_d[WIDTH-1:0] = wrap_diff($signed(cic_out_p2[0]), $signed(cic_out_p2[1]));
`endif
    end

    // Readout control
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state, state_nx;
    logic           trig_q;
    logic           trig_edge;
    logic           load;
    logic           advance;
    logic           overrun_nx;
    logic [L-1:0]   shreg;
    logic [BW-1:0]  bit_cnt;

    assign trig_edge = trigger & ~trig_q;

    always_comb begin
        state_nx   = state;
        load       = 1'b0;
        advance    = 1'b0;
        overrun_nx = 1'b0;
        case (state)
            IDLE: begin
                if (trig_edge) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                overrun_nx = trig_edge;
                if (bit_cnt == BIT_LAST) state_nx = IDLE;
                else                     advance  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            trig_q  <= 1'b1;
            overrun <= 1'b0;
        end else begin
            state   <= state_nx;
            trig_q  <= trigger;
            overrun <= overrun_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= snap_d;
            bit_cnt <= '0;
        end else if (advance) begin
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + BW'(1);
        end
    end

    assign ser_valid = (state == SHIFT);
    assign busy      = ser_valid;
    assign ser_frame = ser_valid && (bit_cnt == '0);
    assign ser_data  = ser_valid & shreg[L-1];

endmodule

// File: tb/tb_ds_adc_multichan.sv
// Bench for ds_adc_multichan: table vectors, random periodic patterns vs. a density model, and readout corner cases.
module tb_ds_adc_multichan;
    localparam int NCH    = 2;
    localparam int STAGES = 4;
    localparam int DECIM  = 8;
    localparam int WIDTH  = 16;
`ifdef DIFF_WORD_EN
    localparam int L = (NCH + 1) * WIDTH;
`else
    localparam int L = NCH * WIDTH;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] cmp_in = '0;
    logic [NCH-1:0] pdm_fb;
    logic           trigger = 1'b0;
    logic           dec_strobe, ser_data, ser_valid, ser_frame, busy, overrun;

    always #5 clk = ~clk;

    ds_adc_multichan #(.NCH(NCH), .STAGES(STAGES), .DECIM(DECIM), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .cmp_in(cmp_in), .pdm_fb(pdm_fb), .trigger(trigger),
        .dec_strobe(dec_strobe), .ser_data(ser_data), .ser_valid(ser_valid),
        .ser_frame(ser_frame), .busy(busy), .overrun(overrun)
    );

    typedef struct {
        logic [7:0]  p0;
        logic [7:0]  p1;
        logic [15:0] e0;
        logic [15:0] e1;
    } vec_t;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] pat0 = '0;
    logic [7:0] pat1 = '0;
    logic [2:0] ph = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
        ph = ph + 3'd1;
        cmp_in = {pat1[ph], pat0[ph]};
    endtask

    // Settled output of a sinc^N decimator is the input density over one decimation period times DECIM^STAGES.
    function automatic logic [15:0] model_word(input logic [7:0] p);
        int n;
        n = $countones(p);
        return 16'((n * (DECIM ** STAGES)) / DECIM);
    endfunction

    function automatic logic [63:0] frame_of(input logic [15:0] w0, input logic [15:0] w1);
`ifdef DIFF_WORD_EN
        logic [15:0] d;
        d = w0 - w1;
        return 64'({w0, w1, d});
`else
        return 64'({w0, w1});
`endif
    endfunction

    task automatic settle();
        int s;
        s = 0;
        for (int i = 0; i < 10 * DECIM; i++) begin
            tick();
            if (dec_strobe === 1'b1) s++;
        end
        check("strobe_count", 64'(s), 64'd10);
    endtask

    task automatic capture(input int ovr_at, output logic [63:0] bits,
                           output int shape_err, output int ovr_cnt);
        bits = '0;
        shape_err = 0;
        ovr_cnt = 0;
        trigger = 1'b1;
        tick();
        for (int k = 0; k < L; k++) begin
            if (ser_valid !== 1'b1 || busy !== 1'b1 || ser_frame !== (k == 0)) shape_err++;
            if (overrun === 1'b1) ovr_cnt++;
            bits[L-1-k] = ser_data;
            if (k == 0) trigger = 1'b0;
            if (ovr_at > 0 && k == ovr_at - 1) trigger = 1'b1;
            tick();
        end
    endtask

    task automatic check_idle(input string nm);
        check(nm, 64'({ser_valid, busy, ser_data, ser_frame}), 64'd0);
    endtask

    initial begin
        vec_t        tbl [6];
        logic [63:0] bits;
        int          shape_err, ovr_cnt, first, vseen;

        tbl[0] = '{8'hFF, 8'h00, 16'h1000, 16'h0000};
        tbl[1] = '{8'h00, 8'hFF, 16'h0000, 16'h1000};
        tbl[2] = '{8'hAA, 8'hFF, 16'h0800, 16'h1000};
        tbl[3] = '{8'h00, 8'h00, 16'h0000, 16'h0000};
        tbl[4] = '{8'h0F, 8'h01, 16'h0800, 16'h0200};
        tbl[5] = '{8'h07, 8'h3F, 16'h0600, 16'h0C00};

        tick();
        tick();
        check("reset_outputs",
              64'({pdm_fb, ser_valid, busy, ser_frame, ser_data, overrun, dec_strobe}), 64'd0);

        // Trigger held high across reset release must not start a frame.
        trigger = 1'b1;
        rst = 1'b0;
        first = 0;
        vseen = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 1) check("pdm_fb_after_release", 64'(pdm_fb), 64'(2'b11));
            if (dec_strobe === 1'b1 && first == 0) first = i;
            if (ser_valid !== 1'b0) vseen++;
        end
        check("first_strobe_cycle", 64'(first), 64'(DECIM));
        check("no_frame_trigger_held", 64'(vseen), 64'd0);
        trigger = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            pat0 = tbl[v].p0;
            pat1 = tbl[v].p1;
            settle();
            capture(0, bits, shape_err, ovr_cnt);
            check("table_frame", bits, frame_of(tbl[v].e0, tbl[v].e1));
            check("table_shape", 64'(shape_err), 64'd0);
            check("table_no_overrun", 64'(ovr_cnt), 64'd0);
            check_idle("table_idle_after");
        end

        // Second trigger edge at bit 20: frame unchanged, one overrun pulse, no follow-on frame.
        pat0 = 8'hFF;
        pat1 = 8'h00;
        settle();
        capture(20, bits, shape_err, ovr_cnt);
        check("ovr_frame", bits, frame_of(16'h1000, 16'h0000));
        check("ovr_shape", 64'(shape_err), 64'd0);
        check("ovr_pulse_count", 64'(ovr_cnt), 64'd1);
        check_idle("ovr_idle_after");
        vseen = 0;
        for (int i = 0; i < 10; i++) begin
            if (ser_valid !== 1'b0 || overrun !== 1'b0) vseen++;
            tick();
        end
        check("ovr_no_second_frame", 64'(vseen), 64'd0);
        trigger = 1'b0;
        tick();

        // Back-to-back frames: the second edge lands on the cycle after the first frame ends.
        capture(0, bits, shape_err, ovr_cnt);
        check("b2b_first_frame", bits, frame_of(16'h1000, 16'h0000));
        capture(0, bits, shape_err, ovr_cnt);
        check("b2b_second_frame", bits, frame_of(16'h1000, 16'h0000));
        check("b2b_second_shape", 64'(shape_err), 64'd0);
        check_idle("b2b_idle_after");

        for (int r = 0; r < 6; r++) begin
            pat0 = 8'($urandom);
            pat1 = 8'($urandom);
            settle();
            for (int d = 0; d < int'($urandom_range(0, 7)); d++) tick();
            capture(0, bits, shape_err, ovr_cnt);
            check("rand_frame", bits, frame_of(model_word(pat0), model_word(pat1)));
            check("rand_shape", 64'(shape_err), 64'd0);
        end

        // Reset at frame bit 10 aborts the frame with no continuation after release.
        pat0 = 8'hFF;
        pat1 = 8'hFF;
        settle();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        check("frame_active_before_reset", 64'({ser_valid, busy}), 64'(2'b11));
        rst = 1'b1;
        tick();
        check_idle("reset_mid_frame");
        check("reset_mid_frame_pdm", 64'(pdm_fb), 64'd0);
        rst = 1'b0;
        vseen = 0;
        for (int i = 0; i < 2 * L; i++) begin
            tick();
            if (ser_valid !== 1'b0) vseen++;
        end
        check("no_bits_after_reset", 64'(vseen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
